// File: rtl/axi_slave_scheduler.sv
// axi_slave_scheduler
//   Per-slave ownership scheduler for a 2-master AXI interconnect. Each slave
//   is arbitrated on its own (round-robin when both masters want it), so
//   different master/slave pairs can run at the same time. Each ownership is
//   tracked through its address phase and its completion phase. A watchdog
//   force-releases a slave that stays busy too long.
//
//   state | meaning
//   IDLE  | slave free, takes part in arbitration
//   ADDR  | owned, waiting for the address handshake
//   RESP  | owned, address accepted, waiting for last beat / write response
//
// Ports
//   ACLK, ARESETn   clock, asynchronous active-low reset
//   ar_req, aw_req  per-master ARVALID / AWVALID
//   ar_tgt, aw_tgt  per-master decoded target slave, master m at [SW*m +: SW]
//   s_addr_hs       per-slave address handshake this cycle
//   s_done          per-slave completion (last read beat or write response)
//   m_gnt           master m owns a slave
//   m_gnt_slv       slave index owned by master m
//   m_gnt_wr        1 = master m owns for a write, 0 = for a read
//   s_busy          slave is owned
//   s_owner         owning master per slave (valid while s_busy)
//   timeout_err     one-cycle pulse when the watchdog releases a slave
module axi_slave_scheduler #(
    parameter int NUM_S   = 3,
    parameter int TIMEOUT = 255,
    localparam int SW     = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [1:0]        ar_req,
    input  logic [1:0]        aw_req,
    input  logic [2*SW-1:0]   ar_tgt,
    input  logic [2*SW-1:0]   aw_tgt,
    input  logic [NUM_S-1:0]  s_addr_hs,
    input  logic [NUM_S-1:0]  s_done,
    output logic [1:0]        m_gnt,
    output logic [2*SW-1:0]   m_gnt_slv,
    output logic [1:0]        m_gnt_wr,
    output logic [NUM_S-1:0]  s_busy,
    output logic [NUM_S-1:0]  s_owner,
    output logic [NUM_S-1:0]  timeout_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(NUM_S - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            st      [NUM_S];
    logic [CW-1:0]     cnt     [NUM_S];
    logic [NUM_S-1:0]  rr_last;

    logic [1:0]        cand_vld;
    logic [1:0]        cand_wr;
    logic [SW-1:0]     tgt     [2];
    logic [SW-1:0]     raw_tgt [2];
    logic [NUM_S-1:0]  gnt_vld;
    logic [NUM_S-1:0]  gnt_m;

    // Candidate request per master: read has priority over write; targets
    // beyond the slave range fall through to the default (last) slave.
    always_comb begin
        cand_vld = '0;
        cand_wr  = '0;
        for (int m = 0; m < 2; m++) begin
            raw_tgt[m]  = ar_req[m] ? ar_tgt[SW*m +: SW] : aw_tgt[SW*m +: SW];
            tgt[m]      = (raw_tgt[m] > S_LAST) ? S_LAST : raw_tgt[m];
            cand_vld[m] = (ar_req[m] | aw_req[m]) & ~m_gnt[m];
            cand_wr[m]  = ~ar_req[m];
        end
    end

    always_comb begin
        gnt_vld = '0;
        gnt_m   = '0;
        for (int s = 0; s < NUM_S; s++) begin
            logic r0, r1;
            r0 = cand_vld[0] && (tgt[0] == SW'(s));
            r1 = cand_vld[1] && (tgt[1] == SW'(s));
            gnt_vld[s] = (st[s] == IDLE) && (r0 || r1);
            gnt_m[s]   = (r0 && r1) ? ~rr_last[s] : r1;
        end
    end

    // A master is only eligible while it owns nothing, so a grant never
    // collides with a release of the same master on one edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int s = 0; s < NUM_S; s++) begin
                st[s]  <= IDLE;
                cnt[s] <= '0;
            end
            rr_last     <= '0;
            m_gnt       <= '0;
            m_gnt_slv   <= '0;
            m_gnt_wr    <= '0;
            s_busy      <= '0;
            s_owner     <= '0;
            timeout_err <= '0;
        end else begin
            timeout_err <= '0;
            for (int s = 0; s < NUM_S; s++) begin
                case (st[s])
                    IDLE: begin
                        cnt[s] <= '0;
                        if (gnt_vld[s]) begin
                            st[s]             <= ADDR;
                            s_busy[s]         <= 1'b1;
                            s_owner[s]        <= gnt_m[s];
                            rr_last[s]        <= gnt_m[s];
                            m_gnt[gnt_m[s]]   <= 1'b1;
                            m_gnt_wr[gnt_m[s]] <= cand_wr[gnt_m[s]];
                            if (gnt_m[s])
                                m_gnt_slv[2*SW-1:SW] <= SW'(s);
                            else
                                m_gnt_slv[SW-1:0] <= SW'(s);
                        end
                    end
                    ADDR: begin
                        // A same-edge s_done is dropped here; the slave keeps
                        // its response valid, so RESP still sees it.
                        if (s_addr_hs[s]) begin
                            st[s]  <= RESP;
                            cnt[s] <= '0;
                        end else if (cnt[s] == CNT_LAST) begin
                            st[s]             <= IDLE;
                            s_busy[s]         <= 1'b0;
                            m_gnt[s_owner[s]] <= 1'b0;
                            timeout_err[s]    <= 1'b1;
                        end else begin
                            cnt[s] <= cnt[s] + CW'(1);
                        end
                    end
                    RESP: begin
                        if (s_done[s]) begin
                            st[s]             <= IDLE;
                            s_busy[s]         <= 1'b0;
                            m_gnt[s_owner[s]] <= 1'b0;
                        end else if (cnt[s] == CNT_LAST) begin
                            st[s]             <= IDLE;
                            s_busy[s]         <= 1'b0;
                            m_gnt[s_owner[s]] <= 1'b0;
                            timeout_err[s]    <= 1'b1;
                        end else begin
                            cnt[s] <= cnt[s] + CW'(1);
                        end
                    end
                    default: begin
                        st[s]  <= IDLE;
                        cnt[s] <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_scheduler.sv
module tb_axi_slave_scheduler;

    localparam int NUM_S = 3;
    localparam int SW    = 2;
    localparam int TO    = 8;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic [1:0]       ar_req, aw_req;
    logic [3:0]       ar_tgt, aw_tgt;
    logic [2:0]       s_addr_hs, s_done;
    logic [1:0]       m_gnt;
    logic [3:0]       m_gnt_slv;
    logic [1:0]       m_gnt_wr;
    logic [2:0]       s_busy, s_owner, timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axi_slave_scheduler #(.NUM_S(NUM_S), .TIMEOUT(TO)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .ar_req      (ar_req),
        .aw_req      (aw_req),
        .ar_tgt      (ar_tgt),
        .aw_tgt      (aw_tgt),
        .s_addr_hs   (s_addr_hs),
        .s_done      (s_done),
        .m_gnt       (m_gnt),
        .m_gnt_slv   (m_gnt_slv),
        .m_gnt_wr    (m_gnt_wr),
        .s_busy      (s_busy),
        .s_owner     (s_owner),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [1:0] ar_req, aw_req;
        logic [3:0] ar_tgt, aw_tgt;
        logic [2:0] hs, done;
        logic [1:0] gnt;
        logic [3:0] slv;
        logic [1:0] wr;
        logic [2:0] busy, owner, terr;
    } vec_t;

    typedef struct {
        int         idx;
        logic [16:0] outs;
    } exp_t;

    vec_t tbl [19];
    exp_t sb  [$];

    function automatic logic [16:0] pack_outs(logic [1:0] g, logic [3:0] sl, logic [1:0] w,
                                              logic [2:0] b, logic [2:0] o, logic [2:0] t);
        return {g, sl, w, b, o, t};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ar_req = '0; aw_req = '0; ar_tgt = '0; aw_tgt = '0;
        s_addr_hs = '0; s_done = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    function automatic logic [16:0] dut_outs();
        return pack_outs(m_gnt, m_gnt_slv, m_gnt_wr, s_busy, s_owner, timeout_err);
    endfunction

    initial begin
        int   winner [3];
        int   nbusy;
        logic seen;
        exp_t e;

        // fields: ar_req aw_req ar_tgt aw_tgt hs done | gnt slv wr busy owner terr
        tbl[0]  = '{2'b01, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b000, 2'b01, 4'b0000, 2'b00, 3'b001, 3'b000, 3'b000};
        tbl[1]  = '{2'b01, 2'b00, 4'b0000, 4'b0000, 3'b001, 3'b000, 2'b01, 4'b0000, 2'b00, 3'b001, 3'b000, 3'b000};
        tbl[2]  = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b001, 2'b00, 4'b0000, 2'b00, 3'b000, 3'b000, 3'b000};
        tbl[3]  = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b000, 2'b00, 4'b0000, 2'b00, 3'b000, 3'b000, 3'b000};
        tbl[4]  = '{2'b01, 2'b10, 4'b0000, 4'b0100, 3'b000, 3'b000, 2'b11, 4'b0100, 2'b10, 3'b011, 3'b010, 3'b000};
        tbl[5]  = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b011, 3'b000, 2'b11, 4'b0100, 2'b10, 3'b011, 3'b010, 3'b000};
        tbl[6]  = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b010, 2'b01, 4'b0100, 2'b10, 3'b001, 3'b010, 3'b000};
        tbl[7]  = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b001, 2'b00, 4'b0100, 2'b10, 3'b000, 3'b010, 3'b000};
        tbl[8]  = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b111, 3'b111, 2'b00, 4'b0100, 2'b10, 3'b000, 3'b010, 3'b000};
        tbl[9]  = '{2'b10, 2'b00, 4'b1100, 4'b0000, 3'b000, 3'b000, 2'b10, 4'b1000, 2'b00, 3'b100, 3'b110, 3'b000};
        tbl[10] = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b100, 2'b10, 4'b1000, 2'b00, 3'b100, 3'b110, 3'b000};
        tbl[11] = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b100, 3'b100, 2'b10, 4'b1000, 2'b00, 3'b100, 3'b110, 3'b000};
        tbl[12] = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b100, 2'b00, 4'b1000, 2'b00, 3'b000, 3'b110, 3'b000};
        tbl[13] = '{2'b10, 2'b10, 4'b0000, 4'b0100, 3'b000, 3'b000, 2'b10, 4'b0000, 2'b00, 3'b001, 3'b111, 3'b000};
        tbl[14] = '{2'b00, 2'b10, 4'b0000, 4'b0100, 3'b001, 3'b000, 2'b10, 4'b0000, 2'b00, 3'b001, 3'b111, 3'b000};
        tbl[15] = '{2'b00, 2'b10, 4'b0000, 4'b0100, 3'b000, 3'b001, 2'b00, 4'b0000, 2'b00, 3'b000, 3'b111, 3'b000};
        tbl[16] = '{2'b00, 2'b10, 4'b0000, 4'b0100, 3'b000, 3'b000, 2'b10, 4'b0100, 2'b10, 3'b010, 3'b111, 3'b000};
        tbl[17] = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b010, 3'b010, 2'b10, 4'b0100, 2'b10, 3'b010, 3'b111, 3'b000};
        tbl[18] = '{2'b00, 2'b00, 4'b0000, 4'b0000, 3'b000, 3'b010, 2'b00, 4'b0100, 2'b10, 3'b000, 3'b111, 3'b000};

        do_reset();
        #1;
        check("reset_state", 32'(dut_outs()), 32'(0));

        // Table: single transactions, concurrency, spurious strobes,
        // out-of-range target, same-edge handshakes, read-over-write.
        for (int i = 0; i < 19; i++) begin
            @(negedge ACLK);
            ar_req = tbl[i].ar_req;  aw_req = tbl[i].aw_req;
            ar_tgt = tbl[i].ar_tgt;  aw_tgt = tbl[i].aw_tgt;
            s_addr_hs = tbl[i].hs;   s_done = tbl[i].done;
            sb.push_back('{i, pack_outs(tbl[i].gnt, tbl[i].slv, tbl[i].wr,
                                        tbl[i].busy, tbl[i].owner, tbl[i].terr)});
            @(posedge ACLK);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (dut_outs() !== e.outs) begin
                n_err++;
                $display("FAIL vec%0d: got gnt=%b slv=%b wr=%b busy=%b owner=%b terr=%b required %b",
                         e.idx, m_gnt, m_gnt_slv, m_gnt_wr, s_busy, s_owner, timeout_err, e.outs);
            end
        end

        // Round-robin on S0 from reset: M1, M0, M1, regrant one cycle after release.
        do_reset();
        winner = '{1, 0, 1};
        @(negedge ACLK);
        ar_req = 2'b11; ar_tgt = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge ACLK); #1;
            check("rr_gnt", 32'(m_gnt), (winner[k] == 1) ? 32'h2 : 32'h1);
            check("rr_owner", 32'(s_owner[0]), 32'(winner[k]));
            @(negedge ACLK); s_addr_hs = 3'b001;
            @(posedge ACLK); #1;
            @(negedge ACLK); s_addr_hs = 3'b000; s_done = 3'b001;
            @(posedge ACLK); #1;
            check("rr_release", 32'(s_busy[0]), 32'(0));
            @(negedge ACLK); s_done = 3'b000;
        end

        // Watchdog, untouched ownership: busy for exactly TO cycles.
        do_reset();
        @(negedge ACLK);
        ar_req = 2'b10; ar_tgt = 4'b0100;
        @(posedge ACLK); #1;
        check("to_grant", 32'(s_busy), 32'h2);
        @(negedge ACLK); ar_req = 2'b00;
        nbusy = 1; seen = 1'b0;
        for (int c = 0; c < 3*TO && !seen; c++) begin
            @(posedge ACLK); #1;
            if (timeout_err[1]) seen = 1'b1;
            else if (s_busy[1]) nbusy++;
        end
        check("to_seen", 32'(seen), 32'(1));
        check("to_len", 32'(nbusy), 32'(TO));
        check("to_release", 32'({m_gnt, s_busy, timeout_err}), 32'({2'b00, 3'b000, 3'b010}));
        @(posedge ACLK); #1;
        check("to_pulse_1cyc", 32'(timeout_err), 32'(0));

        // Watchdog restarts on the address handshake.
        @(negedge ACLK);
        ar_req = 2'b10; ar_tgt = 4'b0100;
        @(posedge ACLK); #1;
        ar_req = 2'b00;
        nbusy = 1; seen = 1'b0;
        for (int c = 0; c < 4*TO && !seen; c++) begin
            @(negedge ACLK);
            s_addr_hs = (nbusy == 4) ? 3'b010 : 3'b000;
            @(posedge ACLK); #1;
            if (timeout_err[1]) seen = 1'b1;
            else if (s_busy[1]) nbusy++;
        end
        s_addr_hs = 3'b000;
        check("to_hs_seen", 32'(seen), 32'(1));
        check("to_hs_len", 32'(nbusy), 32'(TO + 4));

        // Asynchronous reset with two slaves owned, then a normal grant.
        do_reset();
        @(negedge ACLK);
        ar_req = 2'b11; ar_tgt = 4'b0100;
        @(posedge ACLK); #1;
        check("rst_pre_busy", 32'(s_busy), 32'h3);
        @(negedge ACLK);
        ar_req = 2'b00;
        #2 ARESETn = 1'b0;
        #1;
        check("rst_async", 32'(dut_outs()), 32'(0));
        @(posedge ACLK); #1;
        check("rst_hold", 32'(dut_outs()), 32'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        ar_req = 2'b01; ar_tgt = 4'b0010;
        @(posedge ACLK); #1;
        check("rst_regrant", 32'({m_gnt, s_busy}), 32'({2'b01, 3'b100}));
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
